// File: rtl/sram_block_mover_pkg.sv
// Shared types and constants for the SRAM block mover: mode encoding, FSM
// state codes and the deepest supported inbound read latency.
package sram_block_mover_pkg;

   localparam int RD_LAT_MAX = 4;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_XOR    = 2'd1,
      MODE_COUNT  = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sram_block_mover_if.sv
// Handshake and SRAM port bundle between the block mover (master) and the
// producer/consumer buffers around it (slave).
interface sram_block_mover_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 8
);
   logic              ib_data_valid;
   logic [ADDR_W:0]   ib_len;
   logic [1:0]        mode;
   logic [DATA_W-1:0] key;
   logic              ib_sram_valid;
   logic              ib_rd_en;
   logic [ADDR_W-1:0] ib_rd_addr;
   logic [DATA_W-1:0] ib_rd_data;
   logic              ob_sram_valid;
   logic              ob_data_valid;
   logic [ADDR_W:0]   ob_len;
   logic              ob_wr_en;
   logic [ADDR_W-1:0] ob_wr_addr;
   logic [DATA_W-1:0] ob_wr_data;
   logic [15:0]       blk_cnt;

   modport master (
      input  ib_data_valid, ib_len, mode, key, ib_rd_data, ob_sram_valid,
      output ib_sram_valid, ib_rd_en, ib_rd_addr, ob_data_valid, ob_len,
             ob_wr_en, ob_wr_addr, ob_wr_data, blk_cnt
   );

   modport slave (
      output ib_data_valid, ib_len, mode, key, ib_rd_data, ob_sram_valid,
      input  ib_sram_valid, ib_rd_en, ib_rd_addr, ob_data_valid, ob_len,
             ob_wr_en, ob_wr_addr, ob_wr_data, blk_cnt
   );
endinterface

// File: rtl/sram_block_mover_pipe.sv
// Read-side delay line matching the inbound SRAM latency, followed by the
// registered mode datapath that produces the outbound write.
module sram_block_mover_pipe
   import sram_block_mover_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  mode_e             mode,
   input  logic [DATA_W-1:0] key,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);
   localparam int LAT = (RD_LAT < 1) ? 1 : (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

   logic [LAT:1]             vld_pipe;
   logic [LAT:1][ADDR_W-1:0] addr_pipe;
   logic [DATA_W-1:0]        res;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_pipe  <= '0;
         addr_pipe <= '0;
      end else begin
         vld_pipe[1]  <= rd_en;
         addr_pipe[1] <= rd_addr;
         for (int i = 2; i <= LAT; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
         end
      end
   end

   // Word index equals the read address, so COUNT reuses the delayed address.
   always_comb begin
      res = rd_data;
      case (mode)
         MODE_XOR:   res = rd_data ^ key;
         MODE_COUNT: res[31:0] = rd_data[31:0] + 32'(addr_pipe[LAT]);
         default:    res = rd_data;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= vld_pipe[LAT];
         if (vld_pipe[LAT]) begin
            wr_addr <= addr_pipe[LAT];
            wr_data <= res;
         end
      end
   end

endmodule

// File: rtl/sram_block_mover.sv
// Moves one block from the inbound SRAM to the outbound SRAM, transforming
// each word on the way; the FSM owns buffer handshakes and read sequencing.
module sram_block_mover
   import sram_block_mover_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1
) (
   input logic               clk,
   input logic               rstn,
   sram_block_mover_if.master bus
);
   state_t            state;
   logic              armed;
   logic              start;
   logic [ADDR_W:0]   len_q;
   mode_e             mode_q;
   logic [DATA_W-1:0] key_q;
   logic [ADDR_W-1:0] last_addr;

   // len 0 and len 2^ADDR_W both give an all-ones last address.
   assign last_addr = ADDR_W'(len_q - 1'b1);
   assign start     = (state == ST_IDLE) && bus.ib_data_valid && armed && bus.ob_sram_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                  armed <= 1'b1;
      else if (!bus.ib_data_valid) armed <= 1'b1;
      else if (start)             armed <= 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state             <= ST_IDLE;
         len_q             <= '0;
         mode_q            <= MODE_BYPASS;
         key_q             <= '0;
         bus.ib_sram_valid <= 1'b1;
         bus.ib_rd_en      <= 1'b0;
         bus.ib_rd_addr    <= '0;
         bus.ob_data_valid <= 1'b0;
         bus.ob_len        <= '0;
         bus.blk_cnt       <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               state             <= ST_RUN;
               len_q             <= bus.ib_len;
               mode_q            <= mode_e'(bus.mode);
               key_q             <= bus.key;
               bus.ib_sram_valid <= 1'b0;
               bus.ib_rd_en      <= 1'b1;
               bus.ib_rd_addr    <= '0;
            end
            ST_RUN: begin
               bus.ib_rd_addr <= bus.ib_rd_addr + 1'b1;
               if (bus.ib_rd_addr == last_addr) begin
                  bus.ib_rd_en <= 1'b0;
                  state        <= ST_DRAIN;
               end
            end
            ST_DRAIN: if (bus.ob_wr_en && bus.ob_wr_addr == last_addr) begin
               state             <= ST_DONE;
               bus.ob_data_valid <= 1'b1;
               bus.ib_sram_valid <= 1'b1;
               bus.blk_cnt       <= bus.blk_cnt + 16'd1;
               bus.ob_len        <= (len_q == '0) ? {1'b1, {ADDR_W{1'b0}}} : len_q;
            end
            ST_DONE: if (!bus.ob_sram_valid) begin
               state             <= ST_IDLE;
               bus.ob_data_valid <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   sram_block_mover_pipe #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_pipe (
      .clk     (clk),
      .rstn    (rstn),
      .rd_en   (bus.ib_rd_en),
      .rd_addr (bus.ib_rd_addr),
      .rd_data (bus.ib_rd_data),
      .mode    (mode_q),
      .key     (key_q),
      .wr_en   (bus.ob_wr_en),
      .wr_addr (bus.ob_wr_addr),
      .wr_data (bus.ob_wr_data)
   );

endmodule

// File: tb/tb_sram_block_mover.sv
// Directed bench: two movers (read latency 1 and 3) share one inbound SRAM
// image; each has its own latency model and outbound write log.
module tb_sram_block_mover;
   localparam int DW = 128;
   localparam int AW = 8;
   localparam logic [95:0] UPPER = 96'h1111_2222_3333_4444_5555_6666;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   sram_block_mover_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
   sram_block_mover_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

   sram_block_mover #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rstn(rstn), .bus(bus1));
   sram_block_mover #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
      .clk(clk), .rstn(rstn), .bus(bus3));

   logic [DW-1:0] imem [256];
   logic [DW-1:0] d1q;
   logic [DW-1:0] d3q [3];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (bus1.ib_rd_en) d1q <= imem[bus1.ib_rd_addr];
   assign bus1.ib_rd_data = d1q;

   always @(posedge clk) begin
      d3q[0] <= imem[bus3.ib_rd_addr];
      d3q[1] <= d3q[0];
      d3q[2] <= d3q[1];
   end
   assign bus3.ib_rd_data = d3q[2];

   int            rd_cyc1 [256];
   int            wr_cyc1 [256];
   logic [DW-1:0] wr_dat1 [256];
   int            nrd1 = 0;
   int            nwr1 = 0;
   int            rd_cyc3 [256];
   int            wr_cyc3 [256];
   logic [DW-1:0] wr_dat3 [256];
   int            nrd3 = 0;
   int            nwr3 = 0;

   always @(posedge clk) begin
      if (bus1.ib_rd_en) begin
         rd_cyc1[bus1.ib_rd_addr] <= cyc;
         nrd1 <= nrd1 + 1;
      end
      if (bus1.ob_wr_en) begin
         wr_cyc1[bus1.ob_wr_addr] <= cyc;
         wr_dat1[bus1.ob_wr_addr] <= bus1.ob_wr_data;
         nwr1 <= nwr1 + 1;
      end
   end

   always @(posedge clk) begin
      if (bus3.ib_rd_en) begin
         rd_cyc3[bus3.ib_rd_addr] <= cyc;
         nrd3 <= nrd3 + 1;
      end
      if (bus3.ob_wr_en) begin
         wr_cyc3[bus3.ob_wr_addr] <= cyc;
         wr_dat3[bus3.ob_wr_addr] <= bus3.ob_wr_data;
         nwr3 <= nwr3 + 1;
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial begin
      int b_rd;
      int b_wr;
      logic [DW-1:0] k;

      bus1.ib_data_valid = 0; bus1.ib_len = '0; bus1.mode = 0; bus1.key = '0; bus1.ob_sram_valid = 0;
      bus3.ib_data_valid = 0; bus3.ib_len = '0; bus3.mode = 0; bus3.key = '0; bus3.ob_sram_valid = 0;
      for (int i = 0; i < 256; i++) imem[i] = '0;
      for (int i = 0; i < 4; i++) imem[i] = DW'(32'h10 + i);

      repeat (2) @(negedge clk);
      chk("rst_ib_sram_valid", DW'(bus1.ib_sram_valid), 1);
      chk("rst_rd_en", DW'(bus1.ib_rd_en), 0);
      chk("rst_wr_en", DW'(bus1.ob_wr_en), 0);
      chk("rst_ob_data_valid", DW'(bus1.ob_data_valid), 0);
      chk("rst_ob_len", DW'(bus1.ob_len), 0);
      chk("rst_blk_cnt", DW'(bus1.blk_cnt), 0);
      chk("rst_wr_data", bus1.ob_wr_data, 0);
      rstn = 1'b1;
      @(negedge clk);

      // BYPASS, 4 words, latency 1
      b_rd = nrd1; b_wr = nwr1;
      bus1.mode = 2'd0; bus1.ib_len = 9'd4; bus1.ob_sram_valid = 1; bus1.ib_data_valid = 1;
      @(negedge clk);
      chk("byp_first_rd_en", DW'(bus1.ib_rd_en), 1);
      chk("byp_first_rd_addr", DW'(bus1.ib_rd_addr), 0);
      chk("byp_ib_sram_busy", DW'(bus1.ib_sram_valid), 0);
      for (int n = 0; n < 40 && !bus1.ob_data_valid; n++) @(negedge clk);
      chk("byp_done", DW'(bus1.ob_data_valid), 1);
      chk("byp_nrd", DW'(nrd1 - b_rd), 4);
      chk("byp_nwr", DW'(nwr1 - b_wr), 4);
      chk("byp_dat0", wr_dat1[0], DW'(32'h10));
      chk("byp_dat3", wr_dat1[3], DW'(32'h13));
      chk("byp_lat0", DW'(wr_cyc1[0] - rd_cyc1[0]), 2);
      chk("byp_lat3", DW'(wr_cyc1[3] - rd_cyc1[3]), 2);
      chk("byp_ob_len", DW'(bus1.ob_len), 4);
      chk("byp_blk_cnt", DW'(bus1.blk_cnt), 1);
      chk("byp_ib_released", DW'(bus1.ib_sram_valid), 1);

      // ib_data_valid held high through DONE->IDLE: no restart
      bus1.ob_sram_valid = 0;
      @(negedge clk);
      chk("hold_ob_dv_drop", DW'(bus1.ob_data_valid), 0);
      b_rd = nrd1;
      bus1.ob_sram_valid = 1;
      repeat (5) @(negedge clk);
      chk("hold_no_restart", DW'(nrd1 - b_rd), 0);

      // COUNT, len 0 -> 256 words
      for (int i = 0; i < 256; i++) imem[i] = {UPPER, 32'hFFFF_FF80 + 32'(i)};
      bus1.mode = 2'd2; bus1.ib_len = 9'd0; bus1.ib_data_valid = 0;
      @(negedge clk);
      b_rd = nrd1; b_wr = nwr1;
      bus1.ib_data_valid = 1;
      @(negedge clk);
      chk("cnt_start", DW'(bus1.ib_rd_en), 1);
      for (int n = 0; n < 400 && !bus1.ob_data_valid; n++) @(negedge clk);
      chk("cnt_done", DW'(bus1.ob_data_valid), 1);
      repeat (3) @(negedge clk);
      chk("cnt_nrd", DW'(nrd1 - b_rd), 256);
      chk("cnt_nwr", DW'(nwr1 - b_wr), 256);
      chk("cnt_dat0", wr_dat1[0], {UPPER, 32'hFFFF_FF80});
      chk("cnt_dat200", wr_dat1[200], {UPPER, 32'h0000_0110});
      chk("cnt_dat255", wr_dat1[255], {UPPER, 32'h0000_017E});
      chk("cnt_lat255", DW'(wr_cyc1[255] - rd_cyc1[255]), 2);
      chk("cnt_ob_len", DW'(bus1.ob_len), 256);
      chk("cnt_blk_cnt", DW'(bus1.blk_cnt), 2);

      // consumer not ready in IDLE holds off the start
      bus1.ob_sram_valid = 0; bus1.ib_data_valid = 0;
      @(negedge clk);
      bus1.mode = 2'd0; bus1.ib_len = 9'd1; bus1.ib_data_valid = 1;
      b_rd = nrd1;
      repeat (4) @(negedge clk);
      chk("obv_no_reads", DW'(nrd1 - b_rd), 0);
      chk("obv_ib_owned", DW'(bus1.ib_sram_valid), 1);
      bus1.ob_sram_valid = 1;
      @(negedge clk);
      chk("obv_start_rd_en", DW'(bus1.ib_rd_en), 1);
      chk("obv_start_addr", DW'(bus1.ib_rd_addr), 0);
      for (int n = 0; n < 20 && !bus1.ob_data_valid; n++) @(negedge clk);
      chk("obv_done", DW'(bus1.ob_data_valid), 1);
      chk("obv_blk_cnt", DW'(bus1.blk_cnt), 3);
      chk("obv_ob_len", DW'(bus1.ob_len), 1);
      chk("obv_dat0", wr_dat1[0], {UPPER, 32'hFFFF_FF80});
      bus1.ob_sram_valid = 0; bus1.ib_data_valid = 0;
      @(negedge clk);

      // XOR on the latency-3 instance; key changes after latch must not matter
      imem[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      imem[1] = '0;
      k = {16{8'hA5}};
      bus3.mode = 2'd1; bus3.key = k; bus3.ib_len = 9'd2; bus3.ob_sram_valid = 1; bus3.ib_data_valid = 1;
      @(negedge clk);
      bus3.key = '0;
      for (int n = 0; n < 30 && !bus3.ob_data_valid; n++) @(negedge clk);
      chk("xor_done", DW'(bus3.ob_data_valid), 1);
      chk("xor_nrd", DW'(nrd3), 2);
      chk("xor_nwr", DW'(nwr3), 2);
      chk("xor_dat0", wr_dat3[0], 128'hA486_E0C2_2C0E_684A_5B79_1F3D_D3F1_97B5);
      chk("xor_dat1", wr_dat3[1], 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5);
      chk("xor_lat0", DW'(wr_cyc3[0] - rd_cyc3[0]), 4);
      chk("xor_lat1", DW'(wr_cyc3[1] - rd_cyc3[1]), 4);
      chk("xor_ob_len", DW'(bus3.ob_len), 2);
      chk("xor_blk_cnt", DW'(bus3.blk_cnt), 1);
      bus3.ob_sram_valid = 0; bus3.ib_data_valid = 0;
      @(negedge clk);

      // reset at the third read of an 8-word block
      for (int i = 0; i < 8; i++) imem[i] = DW'(i + 1);
      bus1.mode = 2'd0; bus1.ib_len = 9'd8; bus1.ob_sram_valid = 1; bus1.ib_data_valid = 1;
      repeat (3) @(negedge clk);
      chk("mid_third_addr", DW'(bus1.ib_rd_addr), 2);
      rstn = 1'b0;
      bus1.ib_data_valid = 0; bus1.ob_sram_valid = 0;
      b_wr = nwr1;
      #1;
      chk("mid_rd_en", DW'(bus1.ib_rd_en), 0);
      chk("mid_rd_addr", DW'(bus1.ib_rd_addr), 0);
      chk("mid_wr_en", DW'(bus1.ob_wr_en), 0);
      chk("mid_wr_addr", DW'(bus1.ob_wr_addr), 0);
      chk("mid_wr_data", bus1.ob_wr_data, 0);
      chk("mid_ib_sram_valid", DW'(bus1.ib_sram_valid), 1);
      chk("mid_ob_data_valid", DW'(bus1.ob_data_valid), 0);
      chk("mid_ob_len", DW'(bus1.ob_len), 0);
      chk("mid_blk_cnt", DW'(bus1.blk_cnt), 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_no_writes", DW'(nwr1 - b_wr), 0);
      chk("mid_blk_cnt_after", DW'(bus1.blk_cnt), 0);
      chk("mid_idle_rd_en", DW'(bus1.ib_rd_en), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
